// File: rtl/av_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package av_arb_pkg;

    // State encodings double as the owner port encodings.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    localparam logic [1:0]  OWNER_NONE  = 2'b00;
    localparam logic [1:0]  OWNER_M0    = 2'b01;
    localparam logic [1:0]  OWNER_M1    = 2'b10;

    localparam logic [15:0] AV_ARB_DEAD = 16'hDEAD;

endpackage

// File: rtl/av_arb_timeout_ctr.sv
// Stall counter and sticky flag used by av_bus_arbiter when AV_ARB_TIMEOUT_EN is defined.
module av_arb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic sysclk,
    input  logic sysreset,
    input  logic stall_i,
    input  logic clr_i,
    input  logic tmo_clear_i,
    output logic force_o,
    output logic sticky_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sticky_q, sticky_d;

    // The stall cycle that sees TIMEOUT_CYCLES-1 is the one that gets forced.
    assign force_o  = stall_i & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign sticky_o = sticky_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !stall_i || force_o) begin
            cnt_d = '0;
        end
        sticky_d = sticky_q;
        if (force_o) begin
            sticky_d = 1'b1;
        end else if (tmo_clear_i) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: rtl/av_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between M0 (MCU) and M1 (visor, lockable).
// Define AV_ARB_TIMEOUT_EN to enable forced completion of stuck transfers.
module av_bus_arbiter
    import av_arb_pkg::*;
#(
    parameter int AW             = 16,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          sysclk,
    input  logic          sysreset,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_writedata,
    input  logic          m0_write,
    input  logic          m0_read,
    output logic          m0_waitrequest,
    output logic [DW-1:0] m0_readdata,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_writedata,
    input  logic          m1_write,
    input  logic          m1_read,
    output logic          m1_waitrequest,
    output logic [DW-1:0] m1_readdata,
    input  logic          m1_lock,
    output logic [AW-1:0] s_address,
    output logic [DW-1:0] s_writedata,
    output logic          s_write,
    output logic          s_read,
    input  logic          s_waitrequest,
    input  logic [DW-1:0] s_readdata,
    output logic [1:0]    owner,
    input  logic          tmo_clear,
    output logic          timeout_sticky
);
    arb_state_t state_q, state_d;
    logic       last_m1_q, last_m1_d;
    logic       req0, req1, own_req, stall, force_cmp, complete;

    assign req0     = m0_write | m0_read;
    assign req1     = m1_write | m1_read;
    assign own_req  = (state_q == ST_OWN0) ? req0 :
                      (state_q == ST_OWN1) ? req1 : 1'b0;
    assign stall    = own_req & s_waitrequest;
    assign complete = own_req & (~s_waitrequest | force_cmp);
    assign owner    = state_q;

`ifdef AV_ARB_TIMEOUT_EN
    av_arb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .sysclk      (sysclk),
        .sysreset    (sysreset),
        .stall_i     (stall),
        .clr_i       (state_d != state_q),
        .tmo_clear_i (tmo_clear),
        .force_o     (force_cmp),
        .sticky_o    (timeout_sticky)
    );
`else
    logic unused_tmo;
    assign unused_tmo     = tmo_clear ^ stall ^ (TIMEOUT_CYCLES == 0);
    assign force_cmp      = 1'b0;
    assign timeout_sticky = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_m1_d = complete ? (state_q == ST_OWN1) : last_m1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_m1_q ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0 || complete) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                // A held lock keeps M1 on the bus so its next transfer needs no bubble.
                if (!req1 || (complete && !m1_lock)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_q   <= ST_IDLE;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_m1_q <= last_m1_d;
        end
    end

    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_write        = 1'b0;
        s_read         = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        unique case (state_q)
            ST_OWN0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_write        = m0_write & ~force_cmp;
                s_read         = m0_read & ~force_cmp;
                m0_waitrequest = s_waitrequest & ~force_cmp;
                m0_readdata    = force_cmp ? DW'(AV_ARB_DEAD) : s_readdata;
            end
            ST_OWN1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_write        = m1_write & ~force_cmp;
                s_read         = m1_read & ~force_cmp;
                m1_waitrequest = s_waitrequest & ~force_cmp;
                m1_readdata    = force_cmp ? DW'(AV_ARB_DEAD) : s_readdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_av_bus_arbiter.sv
// Directed self-checking bench for av_bus_arbiter; timeout checks follow AV_ARB_TIMEOUT_EN.
module tb_av_bus_arbiter;
    logic        sysclk;
    logic        sysreset;
    logic [15:0] m0_address, m0_writedata, m0_readdata;
    logic        m0_write, m0_read, m0_waitrequest;
    logic [15:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_write, m1_read, m1_waitrequest, m1_lock;
    logic [15:0] s_address, s_writedata, s_readdata;
    logic        s_write, s_read, s_waitrequest;
    logic [1:0]  owner;
    logic        tmo_clear, timeout_sticky;

    int n_total = 0;
    int n_bad   = 0;

    av_bus_arbiter #(
        .AW             (16),
        .DW             (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .sysclk         (sysclk),
        .sysreset       (sysreset),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_write       (m0_write),
        .m0_read        (m0_read),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_read        (m1_read),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .m1_lock        (m1_lock),
        .s_address      (s_address),
        .s_writedata    (s_writedata),
        .s_write        (s_write),
        .s_read         (s_read),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .owner          (owner),
        .tmo_clear      (tmo_clear),
        .timeout_sticky (timeout_sticky)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        sysreset = 1'b1;
        tick();
        sysreset = 1'b0;
    endtask

    initial begin
        sysreset = 1'b1;
        m0_address = '0; m0_writedata = '0; m0_write = 1'b0; m0_read = 1'b0;
        m1_address = '0; m1_writedata = '0; m1_write = 1'b0; m1_read = 1'b0;
        m1_lock = 1'b0; s_waitrequest = 1'b0; s_readdata = '0; tmo_clear = 1'b0;
        #2;
        chk("rst_owner", 32'(owner), 0);
        chk("rst_s_write", 32'(s_write), 0);
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("rst_sticky", 32'(timeout_sticky), 0);
        tick();
        sysreset = 1'b0;

        // single M0 write
        m0_address = 16'h0010; m0_writedata = 16'h1234; m0_write = 1'b1;
        #1;
        chk("t1_idle_owner", 32'(owner), 0);
        chk("t1_idle_wait", 32'(m0_waitrequest), 1);
        tick();
        chk("t1_owner", 32'(owner), 1);
        chk("t1_s_write", 32'(s_write), 1);
        chk("t1_s_addr", 32'(s_address), 32'h0010);
        chk("t1_s_wdata", 32'(s_writedata), 32'h1234);
        chk("t1_m0_wait", 32'(m0_waitrequest), 0);
        chk("t1_m1_wait", 32'(m1_waitrequest), 1);
        tick();
        m0_write = 1'b0;
        chk("t1_done_owner", 32'(owner), 0);
        chk("t1_done_s_write", 32'(s_write), 0);

        // simultaneous requests alternate, M0 first after reset
        do_reset();
        m0_read = 1'b1; m0_address = 16'h0020;
        m1_read = 1'b1; m1_address = 16'h0030;
        s_readdata = 16'h5555;
        tick();
        chk("t2_first_owner", 32'(owner), 1);
        chk("t2_s_addr0", 32'(s_address), 32'h0020);
        chk("t2_s_read", 32'(s_read), 1);
        chk("t2_m0_rdata", 32'(m0_readdata), 32'h5555);
        chk("t2_m1_rdata", 32'(m1_readdata), 0);
        chk("t2_m1_wait", 32'(m1_waitrequest), 1);
        tick();
        chk("t2_bubble", 32'(owner), 0);
        tick();
        chk("t2_second_owner", 32'(owner), 2);
        chk("t2_s_addr1", 32'(s_address), 32'h0030);
        chk("t2_m1_rdata1", 32'(m1_readdata), 32'h5555);
        tick();
        chk("t2_bubble2", 32'(owner), 0);
        tick();
        chk("t2_third_owner", 32'(owner), 1);
        tick();
        m0_read = 1'b0; m1_read = 1'b0;
        chk("t2_end_owner", 32'(owner), 0);

        // locked M1 burst while M0 waits
        m1_read = 1'b1; m1_lock = 1'b1; m1_address = 16'h0040;
        m0_write = 1'b1; m0_address = 16'h0050; m0_writedata = 16'hAAAA;
        tick();
        for (int i = 0; i < 3; i++) begin
            s_readdata = 16'h1000 + 16'(i);
            if (i == 2) m1_lock = 1'b0;
            #1;
            chk("t3_lock_owner", 32'(owner), 2);
            chk("t3_lock_s_read", 32'(s_read), 1);
            chk("t3_lock_rdata", 32'(m1_readdata), 32'h1000 + i);
            chk("t3_m0_starve", 32'(m0_waitrequest), 1);
            tick();
        end
        m1_read = 1'b0;
        chk("t3_unlock_idle", 32'(owner), 0);
        tick();
        chk("t3_m0_owner", 32'(owner), 1);
        chk("t3_m0_s_write", 32'(s_write), 1);
        chk("t3_m0_s_addr", 32'(s_address), 32'h0050);
        tick();
        m0_write = 1'b0;
        chk("t3_end_owner", 32'(owner), 0);

        // slave stalls five cycles on an M1 read
        m1_read = 1'b1; m1_address = 16'h0060; s_waitrequest = 1'b1; s_readdata = '0;
        tick();
        chk("t4_owner", 32'(owner), 2);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_wait", 32'(m1_waitrequest), 1);
            tick();
        end
        s_waitrequest = 1'b0; s_readdata = 16'hBEEF;
        #1;
        chk("t4_ack_wait", 32'(m1_waitrequest), 0);
        chk("t4_ack_rdata", 32'(m1_readdata), 32'hBEEF);
        tick();
        m1_read = 1'b0;
        chk("t4_after_rdata", 32'(m1_readdata), 0);
        chk("t4_after_owner", 32'(owner), 0);

        // stuck slave
        m0_read = 1'b1; m0_address = 16'h0070; s_waitrequest = 1'b1;
        tick();
        chk("t5_owner", 32'(owner), 1);
`ifdef AV_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            chk("t5_stall_wait", 32'(m0_waitrequest), 1);
            tick();
        end
        chk("t5_force_wait", 32'(m0_waitrequest), 0);
        chk("t5_force_rdata", 32'(m0_readdata), 32'hDEAD);
        chk("t5_force_s_read", 32'(s_read), 0);
        tick();
        m0_read = 1'b0;
        chk("t5_force_idle", 32'(owner), 0);
        chk("t5_sticky_set", 32'(timeout_sticky), 1);
        tmo_clear = 1'b1;
        tick();
        tmo_clear = 1'b0;
        chk("t5_sticky_clr", 32'(timeout_sticky), 0);
`else
        for (int i = 0; i < 10; i++) begin
            chk("t5_stall_wait", 32'(m0_waitrequest), 1);
            tick();
        end
        chk("t5_no_sticky", 32'(timeout_sticky), 0);
        m0_read = 1'b0;
        tick();
        chk("t5_abort_idle", 32'(owner), 0);
`endif

        // owner drops request mid-stall
        m1_read = 1'b1; m1_address = 16'h0080;
        tick();
        chk("t5b_owner", 32'(owner), 2);
        tick();
        m1_read = 1'b0;
        tick();
        chk("t5b_abort_idle", 32'(owner), 0);
        s_waitrequest = 1'b0;

        // make M0 the last owner, then reset during an M1 stall
        m0_write = 1'b1; m0_address = 16'h0090;
        tick();
        chk("t6_pre_owner", 32'(owner), 1);
        tick();
        m0_write = 1'b0;
        m1_read = 1'b1; s_waitrequest = 1'b1;
        tick();
        chk("t6_m1_owner", 32'(owner), 2);
        tick();
        sysreset = 1'b1;
        #1;
        chk("t6_rst_owner", 32'(owner), 0);
        chk("t6_rst_s_read", 32'(s_read), 0);
        chk("t6_rst_m1_wait", 32'(m1_waitrequest), 1);
        sysreset = 1'b0;
        m0_write = 1'b1;
        tick();
        chk("t6_tie_m0", 32'(owner), 1);
        s_waitrequest = 1'b0;
        tick();
        m0_write = 1'b0; m1_read = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
